// File: rtl/dmux8way8bit_reg.sv
// Registered 8-way, 8-bit demultiplexer with per-lane one-cycle write strobe.
// Optional auto-increment target pointer enabled by DMUX8WAY8BIT_AUTOINC_EN.
module dmux8way8bit_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic [2:0] select,
    input  logic       load,
    input  logic       clear,
    input  logic       auto,
    output logic [7:0] outA,
    output logic [7:0] outB,
    output logic [7:0] outC,
    output logic [7:0] outD,
    output logic [7:0] outE,
    output logic [7:0] outF,
    output logic [7:0] outG,
    output logic [7:0] outH,
    output logic [7:0] strobe,
    output logic [2:0] ptr
);
    localparam int unsigned W  = 8;
    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;

    logic [N-1:0][W-1:0] regs_q, regs_d;
    logic [N-1:0]        strobe_q, strobe_d;
    logic [SW-1:0]       tgt_c;

`ifdef DMUX8WAY8BIT_AUTOINC_EN
    logic [SW-1:0] ptr_q, ptr_d;

    assign tgt_c = auto ? ptr_q : select;

    // Pointer advances only on accepted auto loads; clear rewinds it.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (load && auto) begin
            ptr_d = ptr_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    logic unused_auto;

    assign unused_auto = auto;
    assign tgt_c       = select;
    assign ptr         = '0;
`endif

    // Clear wins over load; strobe marks only the lane written this cycle.
    always_comb begin
        regs_d   = regs_q;
        strobe_d = '0;
        if (clear) begin
            regs_d = '0;
        end else if (load) begin
            regs_d[tgt_c] = in;
            strobe_d      = N'(1) << tgt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '0;
            strobe_q <= '0;
        end else begin
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
        end
    end

    assign outA   = regs_q[0];
    assign outB   = regs_q[1];
    assign outC   = regs_q[2];
    assign outD   = regs_q[3];
    assign outE   = regs_q[4];
    assign outF   = regs_q[5];
    assign outG   = regs_q[6];
    assign outH   = regs_q[7];
    assign strobe = strobe_q;
endmodule
